// File: rtl/irrigation_controller_if.sv
// Bundle of tank probes, weather/soil sensors and valve/status outputs of the irrigation controller.
interface irrigation_controller_if;
    logic       h;
    logic       m;
    logic       l;
    logic       s;
    logic       t;
    logic       u;
    logic       fill;
    logic       spr;
    logic       drip;
    logic       alarm;
    logic [2:0] state;

    modport master (
        output h, m, l, s, t, u,
        input  fill, spr, drip, alarm, state
    );

    modport slave (
        input  h, m, l, s, t, u,
        output fill, spr, drip, alarm, state
    );
endinterface

// File: rtl/irrigation_controller.sv
// Tank-fed garden irrigation: chooses sprinkler or drip from synchronized sensors,
// times runs with a prescaled tick, enforces a rest pause and keeps the tank topped up.
module irrigation_controller #(
    parameter int TICK_DIV   = 1000,
    parameter int SPR_TICKS  = 10,
    parameter int DRIP_TICKS = 30,
    parameter int REST_TICKS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    irrigation_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPRINKLE = 3'd1,
        DRIP     = 3'd2,
        REST     = 3'd3,
        FAULT    = 3'd4
    } state_t;

    logic [5:0]  meta;
    logic [5:0]  sync;
    logic        h_s, m_s, l_s, s_s, t_s, u_s;
    logic        lvl_empty, lvl_low, lvl_mid, lvl_full, lvl_invalid;
    logic [15:0] pre_cnt;
    logic        tick;
    logic [7:0]  run_cnt;
    logic        spr_done, drip_done, rest_done;
    state_t      state_q;
    state_t      next_state;
    logic        fill_q, spr_q, drip_q, alarm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {bus.h, bus.m, bus.l, bus.s, bus.t, bus.u};
            sync <= meta;
        end
    end

    assign {h_s, m_s, l_s, s_s, t_s, u_s} = sync;

    assign lvl_empty   = ({h_s, m_s, l_s} == 3'b000);
    assign lvl_low     = ({h_s, m_s, l_s} == 3'b001);
    assign lvl_mid     = ({h_s, m_s, l_s} == 3'b011);
    assign lvl_full    = ({h_s, m_s, l_s} == 3'b111);
    assign lvl_invalid = !(lvl_empty || lvl_low || lvl_mid || lvl_full);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    assign tick = (pre_cnt == 16'(TICK_DIV - 1));

    // A run ends on the edge carrying its Nth tick, so N ticks last (N-1)*TICK_DIV+1 .. N*TICK_DIV cycles.
    assign spr_done  = tick && (run_cnt == 8'(SPR_TICKS - 1));
    assign drip_done = tick && (run_cnt == 8'(DRIP_TICKS - 1));
    assign rest_done = tick && (run_cnt == 8'(REST_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (next_state != state_q || state_q == IDLE || state_q == FAULT) begin
            run_cnt <= '0;
        end else if (tick) begin
            run_cnt <= run_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // An invalid probe pattern overrides every other transition.
    always_comb begin
        next_state = IDLE;
        if (lvl_invalid) begin
            next_state = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    next_state = IDLE;
                    if (s_s && (lvl_mid || lvl_full)) begin
                        next_state = (t_s && !u_s) ? SPRINKLE : DRIP;
                    end else if (s_s && lvl_low) begin
                        next_state = DRIP;
                    end
                end
                SPRINKLE: begin
                    next_state = SPRINKLE;
                    if (spr_done || !s_s || lvl_empty || lvl_low) begin
                        next_state = REST;
                    end
                end
                DRIP: begin
                    next_state = DRIP;
                    if (drip_done || !s_s || lvl_empty) begin
                        next_state = REST;
                    end
                end
                REST: begin
                    next_state = rest_done ? IDLE : REST;
                end
                FAULT: begin
                    next_state = REST;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state code.
    always_ff @(posedge clk) begin
        if (rst) begin
            spr_q   <= 1'b0;
            drip_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            spr_q   <= (next_state == SPRINKLE);
            drip_q  <= (next_state == DRIP);
            alarm_q <= (next_state == FAULT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else if (next_state == FAULT) begin
            fill_q <= 1'b0;
        end else if (lvl_empty || lvl_low) begin
            fill_q <= 1'b1;
        end else if (lvl_full) begin
            fill_q <= 1'b0;
        end
    end

    assign bus.state = state_q;
    assign bus.fill  = fill_q;
    assign bus.spr   = spr_q;
    assign bus.drip  = drip_q;
    assign bus.alarm = alarm_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// Directed bench for irrigation_controller with a short tick (TICK_DIV=4) so run timing is observable.
module tb_irrigation_controller;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cnt;

    always #5 clk = ~clk;

    irrigation_controller_if bus ();

    irrigation_controller #(
        .TICK_DIV   (4),
        .SPR_TICKS  (3),
        .DRIP_TICKS (5),
        .REST_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] hml, input logic s_v, input logic t_v, input logic u_v);
        {bus.h, bus.m, bus.l} = hml;
        bus.s = s_v;
        bus.t = t_v;
        bus.u = u_v;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic f,
                              input logic sp, input logic dr, input logic al);
        check_output({tag, "_state"}, 32'(bus.state), 32'(st));
        check_output({tag, "_fill"},  32'(bus.fill),  32'(f));
        check_output({tag, "_spr"},   32'(bus.spr),   32'(sp));
        check_output({tag, "_drip"},  32'(bus.drip),  32'(dr));
        check_output({tag, "_alarm"}, 32'(bus.alarm), 32'(al));
    endtask

    task automatic measure(input logic [2:0] st, output int n);
        n = 1;
        while (bus.state === st && n < 40) begin
            step(1);
            if (bus.state === st) n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int limit, input string tag);
        int n = 0;
        while (bus.state !== st && n < limit) begin
            step(1);
            n++;
        end
        check_output(tag, 32'(bus.state), 32'(st));
    endtask

    initial begin
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(2);
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] sprinkler run on full tank");
        apply_stimulus(3'b111, 1'b1, 1'b1, 1'b0);
        step(2);
        check_output("spr_before_latency", 32'(bus.spr), 32'd0);
        step(1);
        check_outs("spr_start", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd1, cnt);
        check_range("spr_length", cnt, 9, 12);
        check_outs("spr_to_rest", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3'b111, 1'b0, 1'b1, 1'b0);
        measure(3'd3, cnt);
        check_range("rest_length", cnt, 5, 8);
        check_output("rest_to_idle", 32'(bus.state), 32'd0);

        $display("[TB] drip on low tank, fill hysteresis, probe fault");
        apply_stimulus(3'b001, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("drip_low", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(3'b011, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("drip_mid_hold", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(3'b111, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("drip_full", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(3'b101, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("fault", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(3'b011, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("fault_exit", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3'b011, 1'b0, 1'b1, 1'b0);
        wait_state(3'd0, 20, "fault_rest_done");

        $display("[TB] sprinkler aborted by soil becoming wet");
        apply_stimulus(3'b011, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("spr_mid", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2);
        apply_stimulus(3'b011, 1'b0, 1'b1, 1'b0);
        step(2);
        check_output("spr_abort_pending", 32'(bus.spr), 32'd1);
        step(1);
        check_outs("spr_abort", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_state(3'd0, 20, "abort_rest_done");

        $display("[TB] reset in the middle of a drip run");
        apply_stimulus(3'b001, 1'b1, 1'b0, 1'b0);
        step(3);
        check_outs("drip_before_rst", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        step(2);
        rst = 1'b1;
        step(1);
        check_outs("mid_run_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        check_output("post_rst_idle1", 32'(bus.state), 32'd0);
        step(1);
        check_output("post_rst_idle2", 32'(bus.state), 32'd0);
        step(1);
        check_output("post_rst_restart_state", 32'(bus.state), 32'd2);
        check_output("post_rst_restart_drip", 32'(bus.drip), 32'd1);
        apply_stimulus(3'b001, 1'b0, 1'b0, 1'b0);
        wait_state(3'd0, 20, "post_rst_rest_done");

        $display("[TB] empty tank blocks watering");
        apply_stimulus(3'b000, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("empty", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        check_output("empty_stays_idle", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irrigation_controller.md
IRRIGATION_CONTROLLER -- requirements
Module: irrigation_controller

Parameters (one per line: name, default, meaning)
REQ-001 SHALL have TICK_DIV, 1000: clock cycles per timer tick, legal range 2..65535.
REQ-002 SHALL have SPR_TICKS, 10: sprinkler run length in ticks, legal range 1..255.
REQ-003 SHALL have DRIP_TICKS, 30: drip run length in ticks, legal range 1..255.
REQ-004 SHALL have REST_TICKS, 5: mandatory pause after any run, in ticks, legal range 1..255.

Interface (name direction width meaning)
REQ-005 SHALL have clk input 1: single system clock, all state on its rising edge.
REQ-006 SHALL have rst input 1: reset, synchronous and active-high.
REQ-007 SHALL have h, m, l input 1 each: tank level probes (high, mid, low), asynchronous to clk.
REQ-008 SHALL have s input 1: soil dry (1 = dry); t input 1: temperature high; u input 1: air humidity high; all asynchronous to clk.
REQ-009 SHALL have fill output 1: tank inlet valve open.
REQ-010 SHALL have spr output 1: sprinkler valve open; drip output 1: drip valve open.
REQ-011 SHALL have alarm output 1: probe fault; state output 3: FSM state code.

Function
REQ-012 SHALL pass h,m,l,s,t,u through a 2-flop synchronizer; all decisions use the synchronized values only.
REQ-013 SHALL register every output; a raw input change stable before edge k is reflected on outputs after edge k+2.
REQ-014 SHALL decode the level as EMPTY (hml=000), LOW (001), MID (011), FULL (111); any other combination is INVALID.
REQ-015 SHALL run a free prescaler pulsing tick for one cycle every TICK_DIV cycles, counting from reset release.
REQ-016 SHALL implement FSM states IDLE=0, SPRINKLE=1, DRIP=2, REST=3, FAULT=4; codes 5..7 unused and recover to IDLE.
REQ-017 SHALL, in IDLE, with s=1 and level MID or FULL: go to SPRINKLE if t=1 and u=0, else DRIP.
REQ-018 SHALL, in IDLE, with s=1 and level LOW: go to DRIP regardless of t,u; with level EMPTY stay IDLE.
REQ-019 SHALL, on entry to SPRINKLE/DRIP/REST, clear an 8-bit run counter incremented on each tick.
REQ-020 SHALL leave SPRINKLE for REST when run counter reaches SPR_TICKS, s=0, or level EMPTY/LOW, whichever first.
REQ-021 SHALL leave DRIP for REST when run counter reaches DRIP_TICKS, s=0, or level EMPTY, whichever first.
REQ-022 SHALL leave REST for IDLE when run counter reaches REST_TICKS; s is ignored in REST.
REQ-023 SHALL enter FAULT from any state when level is INVALID; INVALID takes priority over all other transitions.
REQ-024 SHALL leave FAULT for REST (run counter cleared) on the first cycle with a valid level.
REQ-025 SHALL drive spr=1 only in SPRINKLE, drip=1 only in DRIP, alarm=1 only in FAULT.
REQ-026 SHALL control fill by hysteresis independent of the FSM: set when level EMPTY or LOW, clear when FULL, hold at MID.
REQ-027 SHALL force fill=0 in FAULT and re-evaluate by REQ-026 from the first cycle after FAULT.
REQ-028 SHALL realise run durations between (N-1)*TICK_DIV+1 and N*TICK_DIV cycles for N ticks.
REQ-029 SHALL, when timer expiry and s=0 coincide, take a single transition to REST.

Reset
REQ-030 SHALL, while rst=1, set state=IDLE, fill=spr=drip=alarm=0, clear prescaler, run counter and synchronizers.
REQ-031 SHALL, on rst mid-run, close every valve on the reset edge and resume in IDLE without passing through REST.

Verification (TICK_DIV=4, SPR_TICKS=3, DRIP_TICKS=5, REST_TICKS=2)
REQ-032 SHALL cover hml=111, s=1, t=1, u=0 -> spr=1 three cycles later, state=1 for 9..12 cycles, then state=3 for 5..8 cycles, then state=0.
REQ-033 SHALL cover hml=001, s=1, t=1 -> drip=1 (not spr), fill=1; raise hml to 011 -> fill holds 1; 111 -> fill=0.
REQ-034 SHALL cover SPRINKLE running, s drops to 0 -> spr=0 and state=3 three cycles after the s edge.
REQ-035 SHALL cover hml=101 during DRIP -> drip=0, fill=0, alarm=1, state=4; hml=011 -> alarm=0, state=3.
REQ-036 SHALL cover rst=1 for one cycle during DRIP -> all outputs 0, state=0 next cycle; with s=1 a new run starts.
REQ-037 SHALL cover hml=000, s=1 -> state stays 0, spr=drip=0, fill=1.
